// File: rtl/link_ddr_downstream_rx.sv
// Receive end of the two-channel DDR link: pairs beats into core words, buffers them, returns credit tokens.
// Optional received-word statistics counter enabled by defining DDR_RX_STATS_EN.
module link_ddr_downstream_rx #(
    parameter int unsigned CHANNEL_WIDTH = 8,
    parameter int unsigned CORE_WIDTH    = 64,
    parameter int unsigned LG_FIFO_DEPTH = 3,
    parameter int unsigned TOKEN_DECIM   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   io_valid_i,
    input  logic [2*CHANNEL_WIDTH-1:0]   io_data_pos_i,
    input  logic [2*CHANNEL_WIDTH-1:0]   io_data_neg_i,
    output logic                         core_valid_o,
    output logic [CORE_WIDTH-1:0]        core_data_o,
    input  logic                         core_yumi_i,
    output logic                         io_token_r_o,
    output logic                         overflow_o,
    output logic                         mismatch_o,
    output logic [15:0]                  rx_word_count_o
);

    localparam int unsigned CH_W   = 2 * CHANNEL_WIDTH;
    localparam int unsigned BEAT_W = 4 * CHANNEL_WIDTH;
    localparam int unsigned DEPTH  = 1 << LG_FIFO_DEPTH;
    localparam int unsigned CNT_W  = LG_FIFO_DEPTH + 1;
    localparam int unsigned TOK_W  = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;

    typedef enum logic {
        LOW,
        HIGH
    } state_t;

    state_t                     state_r, state_nxt;
    logic [BEAT_W-1:0]          beat_c;
    logic [BEAT_W-1:0]          low_r;
    logic [CORE_WIDTH-1:0]      word_c;
    logic                       beat_ok_c;
    logic                       mismatch_c;
    logic                       low_load_c;
    logic                       enq_req_c;
    logic                       full_c;
    logic                       deq_c;
    logic                       enq_c;

    logic [CORE_WIDTH-1:0]      mem_r [DEPTH];
    logic [LG_FIFO_DEPTH-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic [TOK_W-1:0]           tok_cnt_r;
    logic                       tok_wrap_c;

    // Beat layout: ch0 pos, ch0 neg, ch1 pos, ch1 neg from LSB upward
    assign beat_c = {io_data_neg_i[CH_W-1:CHANNEL_WIDTH], io_data_pos_i[CH_W-1:CHANNEL_WIDTH],
                     io_data_neg_i[CHANNEL_WIDTH-1:0],    io_data_pos_i[CHANNEL_WIDTH-1:0]};
    assign word_c     = {beat_c, low_r};
    assign beat_ok_c  = (io_valid_i == 2'b11);
    assign mismatch_c = ^io_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOW;
            low_r   <= '0;
        end else begin
            state_r <= state_nxt;
            if (low_load_c) low_r <= beat_c;
        end
    end

    // Assembler next state: a mismatched beat counts as no beat
    always_comb begin
        state_nxt  = state_r;
        low_load_c = 1'b0;
        enq_req_c  = 1'b0;
        case (state_r)
            LOW: begin
                if (beat_ok_c) begin
                    low_load_c = 1'b1;
                    state_nxt  = HIGH;
                end
            end
            HIGH: begin
                if (beat_ok_c) begin
                    enq_req_c = 1'b1;
                    state_nxt = LOW;
                end
            end
            default: state_nxt = LOW;
        endcase
    end

    // A full FIFO still accepts when the head leaves in the same cycle
    assign full_c = (count_r == CNT_W'(DEPTH));
    assign deq_c  = core_yumi_i && (count_r != '0);
    assign enq_c  = enq_req_c && (!full_c || deq_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq_c) wr_ptr_r <= wr_ptr_r + LG_FIFO_DEPTH'(1);
            if (deq_c) rd_ptr_r <= rd_ptr_r + LG_FIFO_DEPTH'(1);
            case ({enq_c, deq_c})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_c) mem_r[wr_ptr_r] <= word_c;
    end

    assign core_valid_o = (count_r != '0);
    assign core_data_o  = core_valid_o ? mem_r[rd_ptr_r] : '0;

    assign tok_wrap_c = deq_c && (tok_cnt_r == TOK_W'(TOKEN_DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_cnt_r    <= '0;
            io_token_r_o <= 1'b0;
            overflow_o   <= 1'b0;
            mismatch_o   <= 1'b0;
        end else begin
            if (deq_c) tok_cnt_r <= tok_wrap_c ? '0 : tok_cnt_r + TOK_W'(1);
            if (tok_wrap_c) io_token_r_o <= ~io_token_r_o;
            if (enq_req_c && !enq_c) overflow_o <= 1'b1;
            if (mismatch_c) mismatch_o <= 1'b1;
        end
    end

`ifdef DDR_RX_STATS_EN
    logic [15:0] rx_cnt_r;

    always_ff @(posedge clk) begin
        if (rst) rx_cnt_r <= '0;
        else if (enq_c && (rx_cnt_r != 16'hFFFF)) rx_cnt_r <= rx_cnt_r + 16'd1;
    end

    assign rx_word_count_o = rx_cnt_r;
`else
    assign rx_word_count_o = 16'd0;
`endif

    // Dequeue from an empty FIFO is a core protocol error
    assert property (@(posedge clk) disable iff (rst) core_yumi_i |-> core_valid_o)
        else $error("core_yumi_i asserted while core_valid_o is low");

endmodule

// File: tb/tb_link_ddr_downstream_rx.sv
// Randomised and directed checks of link_ddr_downstream_rx against a queue-based reference model.
module tb_link_ddr_downstream_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  io_valid_i = 2'b00;
    logic [15:0] io_data_pos_i = '0;
    logic [15:0] io_data_neg_i = '0;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i = 1'b0;
    logic        io_token_r_o;
    logic        overflow_o;
    logic        mismatch_o;
    logic [15:0] rx_word_count_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] mq[$];
    bit          m_have_low;
    logic [31:0] m_low;
    bit          m_ovf, m_mis;
    int          m_ndeq, m_acc;

    link_ddr_downstream_rx dut (
        .clk(clk), .rst(rst), .io_valid_i(io_valid_i),
        .io_data_pos_i(io_data_pos_i), .io_data_neg_i(io_data_neg_i),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_yumi_i(core_yumi_i),
        .io_token_r_o(io_token_r_o), .overflow_o(overflow_o), .mismatch_o(mismatch_o),
        .rx_word_count_o(rx_word_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic m_tok();
        return ((m_ndeq / 4) % 2) == 1;
    endfunction

    function automatic logic [63:0] m_head();
        return (mq.size() > 0) ? mq[0] : 64'd0;
    endfunction

    function automatic logic [15:0] m_cnt();
`ifdef DDR_RX_STATS_EN
        return (m_acc > 65535) ? 16'hFFFF : 16'(m_acc);
`else
        return 16'd0;
`endif
    endfunction

    // Model of one clock edge, from the behavioural rules of the link
    task automatic model_update();
        logic [31:0] beat;
        bit deq;
        beat = {io_data_neg_i[15:8], io_data_pos_i[15:8], io_data_neg_i[7:0], io_data_pos_i[7:0]};
        if (rst) begin
            mq.delete();
            m_have_low = 0; m_low = '0; m_ovf = 0; m_mis = 0; m_ndeq = 0; m_acc = 0;
            return;
        end
        deq = core_yumi_i && (mq.size() > 0);
        if (io_valid_i == 2'b01 || io_valid_i == 2'b10) m_mis = 1;
        if (deq) begin
            void'(mq.pop_front());
            m_ndeq++;
        end
        if (io_valid_i == 2'b11) begin
            if (!m_have_low) begin
                m_low = beat;
                m_have_low = 1;
            end else begin
                m_have_low = 0;
                if (mq.size() < 8) begin
                    mq.push_back({beat, m_low});
                    m_acc++;
                end else m_ovf = 1;
            end
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] beat, input logic y);
        io_valid_i    = v;
        io_data_pos_i = {beat[23:16], beat[7:0]};
        io_data_neg_i = {beat[31:24], beat[15:8]};
        core_yumi_i   = y;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2'b00, 32'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        step(2'b11, w[31:0], 1'b0);
        step(2'b11, w[63:32], 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({core_valid_o, core_data_o, io_token_r_o, overflow_o, mismatch_o, rx_word_count_o} !== 84'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%h tok=%b ovf=%b mis=%b cnt=%0d, required all zero",
                     core_valid_o, core_data_o, io_token_r_o, overflow_o, mismatch_o, rx_word_count_o);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        step(2'b11, 32'h33221100, 1'b0);
        n_vec++;
        if (core_valid_o !== 1'b0) begin
            n_err++; $display("FAIL single_half_valid: got %b need 0", core_valid_o);
        end
        step(2'b11, 32'h77665544, 1'b0);
        n_vec++;
        if (core_valid_o !== 1'b1 || core_data_o !== 64'h7766554433221100) begin
            n_err++;
            $display("FAIL single_word: valid=%b data=%h need 1 7766554433221100", core_valid_o, core_data_o);
        end
    endtask

    task automatic test_gapped();
        logic [31:0] a, b;
        do_reset();
        a = $urandom; b = $urandom;
        step(2'b11, a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, $urandom, 1'b0);
            n_vec++;
            if (core_valid_o !== 1'b0) begin
                n_err++; $display("FAIL gapped_early gap%0d: valid=%b need 0", i, core_valid_o);
            end
        end
        step(2'b11, b, 1'b0);
        n_vec++;
        if (core_valid_o !== 1'b1 || core_data_o !== {b, a}) begin
            n_err++; $display("FAIL gapped_word: valid=%b data=%h need 1 %h", core_valid_o, core_data_o, {b, a});
        end
        step(2'b00, 32'd0, 1'b1);
        n_vec++;
        if (core_valid_o !== 1'b0) begin
            n_err++; $display("FAIL gapped_single: valid=%b need 0 after one dequeue", core_valid_o);
        end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] w [9];
        do_reset();
        for (int i = 0; i < 9; i++) begin
            w[i] = {$urandom, $urandom};
            send_word(w[i]);
            n_vec++;
            if (overflow_o !== (i == 8) || core_valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL fill_word%0d: ovf=%b valid=%b need %b 1", i + 1, overflow_o, core_valid_o, i == 8);
            end
        end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (core_valid_o !== 1'b1 || core_data_o !== w[i]) begin
                n_err++;
                $display("FAIL fill_order%0d: valid=%b data=%h need 1 %h", i + 1, core_valid_o, core_data_o, w[i]);
            end
            step(2'b00, 32'd0, 1'b1);
        end
        n_vec++;
        if (core_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            n_err++; $display("FAIL fill_drained: valid=%b ovf=%b need 0 1", core_valid_o, overflow_o);
        end
    endtask

    task automatic test_simultaneous_full();
        logic [63:0] w [9];
        do_reset();
        for (int i = 0; i < 9; i++) w[i] = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) send_word(w[i]);
        step(2'b11, w[8][31:0], 1'b0);
        step(2'b11, w[8][63:32], 1'b1);
        n_vec++;
        if (overflow_o !== 1'b0 || core_data_o !== w[1]) begin
            n_err++; $display("FAIL simul_full: ovf=%b head=%h need 0 %h", overflow_o, core_data_o, w[1]);
        end
        n_vec++;
        if (rx_word_count_o !== m_cnt()) begin
            n_err++; $display("FAIL simul_count: got %0d need %0d", rx_word_count_o, m_cnt());
        end
        for (int i = 1; i < 9; i++) begin
            n_vec++;
            if (core_valid_o !== 1'b1 || core_data_o !== w[i]) begin
                n_err++;
                $display("FAIL simul_order%0d: valid=%b data=%h need 1 %h", i + 1, core_valid_o, core_data_o, w[i]);
            end
            step(2'b00, 32'd0, 1'b1);
        end
        n_vec++;
        if (core_valid_o !== 1'b0) begin
            n_err++; $display("FAIL simul_occupancy: valid=%b need 0 after 8 dequeues", core_valid_o);
        end
    endtask

    task automatic test_token();
        do_reset();
        for (int i = 0; i < 8; i++) send_word({$urandom, $urandom});
        for (int k = 1; k <= 8; k++) begin
            step(2'b00, 32'd0, 1'b1);
            n_vec++;
            if (io_token_r_o !== (k >= 4 && k < 8)) begin
                n_err++;
                $display("FAIL token_deq%0d: got %b need %b", k, io_token_r_o, k >= 4 && k < 8);
            end
        end
    endtask

    task automatic test_mismatch_reset();
        logic [31:0] a, c, d;
        do_reset();
        a = $urandom; c = $urandom; d = $urandom;
        step(2'b11, a, 1'b0);
        step(2'b01, $urandom, 1'b0);
        n_vec++;
        if (mismatch_o !== 1'b1 || core_valid_o !== 1'b0) begin
            n_err++; $display("FAIL mismatch_flag: mis=%b valid=%b need 1 0", mismatch_o, core_valid_o);
        end
        do_reset();
        step(2'b11, c, 1'b0);
        n_vec++;
        if (core_valid_o !== 1'b0) begin
            n_err++; $display("FAIL reset_midword: valid=%b need 0 after first beat", core_valid_o);
        end
        step(2'b11, d, 1'b0);
        n_vec++;
        if (core_data_o !== {d, c} || mismatch_o !== 1'b0 || core_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_word: data=%h mis=%b valid=%b need %h 0 1", core_data_o, mismatch_o, core_valid_o, {d, c});
        end
        n_vec++;
`ifdef DDR_RX_STATS_EN
        if (rx_word_count_o !== 16'd1) begin
            n_err++; $display("FAIL reset_count: got %0d need 1", rx_word_count_o);
        end
`else
        if (rx_word_count_o !== 16'd0) begin
            n_err++; $display("FAIL reset_count: got %0d need 0", rx_word_count_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [1:0] v;
        int r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            v = (r < 60) ? 2'b11 : (r < 96) ? 2'b00 : (r < 98) ? 2'b01 : 2'b10;
            rst = ($urandom_range(0, 199) == 0);
            step(v, $urandom, (mq.size() > 0) && ($urandom_range(0, 99) < 40));
            rst = 1'b0;
            n_vec++;
            if (core_valid_o !== (mq.size() > 0) || core_data_o !== m_head() || io_token_r_o !== m_tok() ||
                overflow_o !== m_ovf || mismatch_o !== m_mis || rx_word_count_o !== m_cnt()) begin
                n_err++;
                $display("FAIL random_cycle%0d: got v=%b d=%h t=%b o=%b m=%b c=%0d need v=%b d=%h t=%b o=%b m=%b c=%0d",
                         i, core_valid_o, core_data_o, io_token_r_o, overflow_o, mismatch_o, rx_word_count_o,
                         mq.size() > 0, m_head(), m_tok(), m_ovf, m_mis, m_cnt());
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_gapped();
        test_fill_overflow();
        test_simultaneous_full();
        test_token();
        test_mismatch_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
